// File: rtl/mesh_link_arb_if.sv
// Bundle of requester-side and link-side signals around the mesh link arbiter.
// The slave modport is the arbiter's view; the master modport is everything driving it.
interface mesh_link_arb_if #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ*WIDTH-1:0] di;
    logic [NREQ-1:0]       si;
    logic [NREQ-1:0]       ri;
    logic [WIDTH-1:0]      dout;
    logic                  so;
    logic                  ro;
    logic [PW-1:0]         gnt_id;

    modport master (
        output di, si, ro,
        input  ri, dout, so, gnt_id
    );

    modport slave (
        input  di, si, ro,
        output ri, dout, so, gnt_id
    );
endinterface

// File: rtl/mesh_link_arb.sv
// Round-robin arbiter feeding a 1-deep output register that drives one mesh link.
// The output register refills in the same cycle it drains, so a busy link sees no bubbles.
module mesh_link_arb #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
) (
    input  logic            clk,
    input  logic            reset,
    mesh_link_arb_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state;
    state_t        stateNext;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    logic          canLoad;
    logic          accept;
    int            idx;

    // Search upward from the priority pointer, wrapping, and take the first requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && bus.si[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Gating with reset keeps ri low while the block is held in reset.
    assign canLoad = (state == EMPTY) || bus.ro;
    assign accept  = canLoad && found && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (accept) begin
            stateNext = FULL;
        end else if (state == FULL && bus.ro) begin
            stateNext = EMPTY;
        end
    end

    always_comb begin
        bus.so = (state == FULL);
        bus.ri = '0;
        if (accept) begin
            bus.ri[win] = 1'b1;
        end
    end

    // Priority only rotates on an accept, so idle cycles leave fairness order untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dout   <= '0;
            bus.gnt_id <= '0;
            ptr        <= '0;
        end else if (accept) begin
            bus.dout   <= bus.di[int'(win)*WIDTH +: WIDTH];
            bus.gnt_id <= win;
            ptr        <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
        end
    end
endmodule

// File: tb/tb_mesh_link_arb.sv
// Directed and random checks of mesh_link_arb against a reference arbiter model
// and a scoreboard of accepted flits.
module tb_mesh_link_arb;
    localparam int WIDTH = 64;
    localparam int NREQ  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mesh_link_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

    mesh_link_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] sbQueue[$];
    logic             mSo  = 1'b0;
    logic [1:0]       mGnt = '0;
    logic [1:0]       mPtr = '0;
    logic [1:0]       mWin;
    logic [3:0]       expRi;
    logic [WIDTH-1:0] expFlit;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] capt;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] modelWin(input logic [3:0] req, input logic [1:0] p);
        logic [1:0] w;
        for (int i = 0; i < NREQ; i++) begin
            w = p + 2'(i);
            if (req[w]) return w;
        end
        return p;
    endfunction

    // Drive one cycle of stimulus just after the rising edge, then stop at the falling edge.
    task automatic applyStimulus(input logic [3:0] s, input logic r);
        @(posedge clk);
        #1;
        bus.si = s;
        bus.ro = r;
        for (int k = 0; k < NREQ; k++) begin
            bus.di[k*WIDTH +: WIDTH] = {$urandom, $urandom};
        end
        @(negedge clk);
    endtask

    task automatic clearModel();
        sbQueue.delete();
        mSo  = 1'b0;
        mGnt = '0;
        mPtr = '0;
    endtask

    // Reference model and scoreboard, evaluated on every falling edge out of reset.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("monSo", bus.so, mSo);
            checkOutput("monGnt", bus.gnt_id, mGnt);
            expRi = '0;
            mWin  = modelWin(bus.si, mPtr);
            if ((!mSo || bus.ro) && (bus.si != '0)) expRi[mWin] = 1'b1;
            checkOutput("monRi", bus.ri, expRi);
            if (mSo && bus.ro) begin
                checkOutput("sbNonEmpty", sbQueue.size() > 0, 1);
                if (sbQueue.size() > 0) begin
                    expFlit = sbQueue.pop_front();
                    checkOutput("sbDout", bus.dout, expFlit);
                end
            end
            if (expRi != '0) begin
                sbQueue.push_back(bus.di[int'(mWin)*WIDTH +: WIDTH]);
                mSo  = 1'b1;
                mGnt = mWin;
                mPtr = mWin + 2'd1;
            end else if (mSo && bus.ro) begin
                mSo = 1'b0;
            end
        end
    end

    initial begin
        bus.si = 4'b1000;
        bus.ro = 1'b0;
        bus.di = '0;
        #1;
        checkOutput("rstSo", bus.so, 0);
        checkOutput("rstDout", bus.dout, 0);
        checkOutput("rstRi", bus.ri, 0);
        checkOutput("rstGnt", bus.gnt_id, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("firstRi", bus.ri, 4'b1000);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("firstSo", bus.so, 1);
        checkOutput("firstGnt", bus.gnt_id, 3);
        checkOutput("fullHoldRi", bus.ri, 0);

        // Reset in the middle of a held flit must empty the register at once.
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midRstSo", bus.so, 0);
        checkOutput("midRstDout", bus.dout, 0);
        checkOutput("midRstRi", bus.ri, 0);
        checkOutput("midRstGnt", bus.gnt_id, 0);
        clearModel();
        bus.si = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput("fairRi", bus.ri, 4'b0001 << (i % 4));
            if (i > 0) begin
                checkOutput("fairGnt", bus.gnt_id, (i - 1) % 4);
                checkOutput("fairSo", bus.so, 1);
            end
        end

        held = '0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0110, 1'b0);
            if (i == 0) held = bus.dout;
            checkOutput("bpRi", bus.ri, 0);
            checkOutput("bpDout", bus.dout, held);
            checkOutput("bpSo", bus.so, 1);
            checkOutput("bpGnt", bus.gnt_id, 3);
        end
        applyStimulus(4'b0110, 1'b1);
        checkOutput("bpReleaseRi", bus.ri, 4'b0010);
        capt = bus.di[1*WIDTH +: WIDTH];
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bpNewDout", bus.dout, capt);
        checkOutput("bpNewGnt", bus.gnt_id, 1);

        applyStimulus(4'b0100, 1'b1);
        checkOutput("wrapSetRi", bus.ri, 4'b0100);
        applyStimulus(4'b0101, 1'b1);
        checkOutput("wrapRi", bus.ri, 4'b0001);
        applyStimulus(4'b0101, 1'b1);
        checkOutput("wrapNextRi", bus.ri, 4'b0100);

        applyStimulus(4'b0010, 1'b1);
        checkOutput("idleSetRi", bus.ri, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b1);
            checkOutput("idleRi", bus.ri, 0);
        end
        applyStimulus(4'b1111, 1'b1);
        checkOutput("idleNoRotRi", bus.ri, 4'b0100);

        for (int i = 0; i < 10000; i++) begin
            applyStimulus(4'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b1);
        end
        checkOutput("sbLeftover", sbQueue.size(), 0);
        checkOutput("finalSo", bus.so, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
